// File: rtl/jts16_obj_dbuf.sv
// rtl/jts16_obj_dbuf.sv - double-buffered object table RAM with front->back copy engine
// CPU owns the front bank, the object scan owns the back bank, a dump port reads either.
module jts16_obj_dbuf #(
  parameter int AW      = 10,
  parameter int DW      = 16,
  parameter int AUTO_VB = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            obj_cs,
  input  logic [AW-1:0]   cpu_addr,
  input  logic [DW-1:0]   cpu_dout,
  input  logic [DW/8-1:0] dsn,
  output logic [DW-1:0]   cpu_din,
  input  logic            swap_req,
  input  logic            vb,
  output logic            copy_busy,
  output logic            copy_done,
  input  logic [AW-1:0]   tbl_addr,
  output logic [DW-1:0]   tbl_dout,
  input  logic            tbl_we,
  input  logic [DW-1:0]   tbl_din,
  input  logic [AW:0]     dump_addr,
  input  logic            dump_en,
  output logic [DW-1:0]   dump_dout
);

  localparam int   NB    = DW / 8;
  localparam int   WORDS = 1 << AW;
  localparam logic VB_EN = (AUTO_VB != 0);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_LAST = 2'd2;

  logic [DW-1:0] front_mem [0:WORDS-1];
  logic [DW-1:0] back_mem  [0:WORDS-1];

  logic [1:0]    state;
  logic [AW-1:0] rd_addr;
  logic [AW-1:0] wr_addr;
  logic          copy_we;
  logic          pending;
  logic          vb_q;
  logic          start;

  logic [DW-1:0] front_q;
  logic [DW-1:0] back_q;
  logic [AW-1:0] front_raddr;
  logic [AW-1:0] back_raddr;
  logic          scan_we;

  logic          dump_sel_q;
  logic          dump_blank_q;

  assign start       = swap_req | (VB_EN & vb & ~vb_q);
  assign front_raddr = copy_busy ? rd_addr : dump_addr[AW-1:0];
  assign back_raddr  = dump_en ? dump_addr[AW-1:0] : tbl_addr;
  assign scan_we     = tbl_we & ~copy_busy & ~dump_en;
  assign tbl_dout    = back_q;

  // Copy engine: RUN reads one front word per cycle, the matching back write
  // trails by one cycle, LAST flushes the final word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      rd_addr   <= '0;
      wr_addr   <= '0;
      copy_we   <= 1'b0;
      copy_busy <= 1'b0;
      copy_done <= 1'b0;
      pending   <= 1'b0;
      vb_q      <= 1'b0;
    end else begin
      vb_q      <= vb;
      copy_done <= 1'b0;
      copy_we   <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start || pending) begin
            state     <= ST_RUN;
            rd_addr   <= '0;
            copy_busy <= 1'b1;
            pending   <= 1'b0;
          end
        end
        ST_RUN: begin
          copy_we <= 1'b1;
          wr_addr <= rd_addr;
          rd_addr <= rd_addr + 1'b1;
          if (rd_addr == {AW{1'b1}}) state <= ST_LAST;
          if (start) pending <= 1'b1;
        end
        ST_LAST: begin
          state     <= ST_IDLE;
          copy_busy <= 1'b0;
          copy_done <= 1'b1;
          if (start) pending <= 1'b1;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Front bank port 0: CPU, byte-enabled, read-first.
  always_ff @(posedge clk) begin
    for (int b = 0; b < NB; b++) begin
      if (obj_cs && !dsn[b]) front_mem[cpu_addr][b*8 +: 8] <= cpu_dout[b*8 +: 8];
    end
    cpu_din <= front_mem[cpu_addr];
  end

  // Front bank port 1: copy read while busy, dump read otherwise.
  always_ff @(posedge clk) begin
    front_q <= front_mem[front_raddr];
  end

  // Back bank: copy write and scan write never overlap because the scan is
  // locked out for the whole time copy_busy is high.
  always_ff @(posedge clk) begin
    if (copy_we) begin
      back_mem[wr_addr] <= front_q;
    end else if (scan_we) begin
      back_mem[tbl_addr] <= tbl_din;
    end
    back_q <= back_mem[back_raddr];
  end

  // Dump output stage; the front bank is blanked if it was being copied.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dump_sel_q   <= 1'b0;
      dump_blank_q <= 1'b0;
      dump_dout    <= '0;
    end else begin
      dump_sel_q   <= dump_addr[AW];
      dump_blank_q <= copy_busy;
      if (dump_sel_q) dump_dout <= dump_blank_q ? '0 : front_q;
      else            dump_dout <= back_q;
    end
  end

endmodule

// File: tb/tb_jts16_obj_dbuf.sv
// tb/tb_jts16_obj_dbuf.sv - randomized self-checking bench for jts16_obj_dbuf
// Front/back banks are modelled as plain arrays updated by the bench's own rules.
module tb_jts16_obj_dbuf;
  localparam int AW = 10;
  localparam int DW = 16;
  localparam int N  = 1 << AW;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          obj_cs;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_dout;
  logic [1:0]    dsn;
  logic          swap_req;
  logic          vb;
  logic [AW-1:0] tbl_addr;
  logic          tbl_we;
  logic [DW-1:0] tbl_din;
  logic [AW:0]   dump_addr;
  logic          dump_en;

  logic [DW-1:0] cpu_din, tbl_dout, dump_dout;
  logic          copy_busy, copy_done;
  logic [DW-1:0] cpu_din0, tbl_dout0, dump_dout0;
  logic          copy_busy0, copy_done0;

  logic [15:0] fm [N];
  logic [15:0] bm [N];
  logic [15:0] snap [N];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  jts16_obj_dbuf #(.AW(AW), .DW(DW), .AUTO_VB(1)) dut (
    .clk(clk), .rst_n(rst_n), .obj_cs(obj_cs), .cpu_addr(cpu_addr), .cpu_dout(cpu_dout),
    .dsn(dsn), .cpu_din(cpu_din), .swap_req(swap_req), .vb(vb), .copy_busy(copy_busy),
    .copy_done(copy_done), .tbl_addr(tbl_addr), .tbl_dout(tbl_dout), .tbl_we(tbl_we),
    .tbl_din(tbl_din), .dump_addr(dump_addr), .dump_en(dump_en), .dump_dout(dump_dout)
  );

  jts16_obj_dbuf #(.AW(AW), .DW(DW), .AUTO_VB(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .obj_cs(obj_cs), .cpu_addr(cpu_addr), .cpu_dout(cpu_dout),
    .dsn(dsn), .cpu_din(cpu_din0), .swap_req(swap_req), .vb(vb), .copy_busy(copy_busy0),
    .copy_done(copy_done0), .tbl_addr(tbl_addr), .tbl_dout(tbl_dout0), .tbl_we(tbl_we),
    .tbl_din(tbl_din), .dump_addr(dump_addr), .dump_en(dump_en), .dump_dout(dump_dout0)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cpu_wr(input int a, input logic [15:0] d, input logic [1:0] ds);
    obj_cs = 1'b1; cpu_addr = a[AW-1:0]; cpu_dout = d; dsn = ds;
    tick();
    obj_cs = 1'b0; dsn = 2'b11;
    if (!ds[0]) fm[a][7:0]  = d[7:0];
    if (!ds[1]) fm[a][15:8] = d[15:8];
  endtask

  task automatic fill_front(input bit rnd);
    for (int i = 0; i < N; i++)
      cpu_wr(i, rnd ? 16'($urandom) : (16'(i) ^ 16'h5A5A), 2'b00);
  endtask

  task automatic do_copy(input string tag);
    int n;
    swap_req = 1'b1;
    tick();
    swap_req = 1'b0;
    n = copy_busy ? 1 : 0;
    while (copy_busy && n < 3000) begin
      tick();
      if (copy_busy) n++;
    end
    check({tag, "_busy_len"}, n, N + 1);
    check({tag, "_done"}, {31'd0, copy_done}, 1);
    tick();
    check({tag, "_done_single"}, {31'd0, copy_done}, 0);
  endtask

  task automatic verify_bank(input bit front, input string tag);
    int bad;
    logic [15:0] exp;
    bad = 0;
    dump_en = ~front;
    for (int j = 0; j <= N; j++) begin
      if (j < N) dump_addr = {front, AW'(j)};
      tick();
      if (j >= 1) begin
        exp = front ? fm[j-1] : bm[j-1];
        if (dump_dout !== exp) bad++;
      end
    end
    dump_en = 1'b0;
    check({tag, "_bad_words"}, bad, 0);
  endtask

  task automatic tbl_rd(input int a, input logic [15:0] exp, input string tag);
    tbl_addr = a[AW-1:0];
    tick();
    check(tag, {16'd0, tbl_dout}, {16'd0, exp});
  endtask

  initial begin
    int t, n, dones, rises, prev, a, done1, rise2, done2, rise3, c1, c0;
    bit pulse_next, do_w;
    logic [15:0] wd;
    logic [1:0] ds;

    rst_n = 1'b0; obj_cs = 1'b0; cpu_addr = '0; cpu_dout = '0; dsn = 2'b11;
    swap_req = 1'b0; vb = 1'b0; tbl_addr = '0; tbl_we = 1'b0; tbl_din = '0;
    dump_addr = '0; dump_en = 1'b0;
    repeat (3) tick();
    check("rst_busy", {31'd0, copy_busy}, 0);
    check("rst_done", {31'd0, copy_done}, 0);
    check("rst_dump", {16'd0, dump_dout}, 0);
    check("rst_busy0", {31'd0, copy_busy0}, 0);
    rst_n = 1'b1;
    tick();

    // basic copy of the addr^5A5A pattern
    fill_front(1'b0);
    do_copy("copy1");
    for (int i = 0; i < N; i++) bm[i] = fm[i];
    verify_bank(1'b0, "back1");
    verify_bank(1'b1, "front1");

    // byte-strobe write, back bank untouched until the next copy
    cpu_wr(3, 16'hFFFF, 2'b00);
    cpu_wr(3, 16'h1234, 2'b10);
    obj_cs = 1'b1; dsn = 2'b11; cpu_addr = 10'd3;
    tick();
    obj_cs = 1'b0;
    check("byte_wr", {16'd0, cpu_din}, 32'h0000FF34);
    tbl_rd(3, bm[3], "back_unchanged");
    for (int k = 0; k < 8; k++) begin
      a = $urandom_range(0, N - 1);
      ds = 2'($urandom_range(0, 3));
      cpu_wr(a, 16'($urandom), ds);
      obj_cs = 1'b1; cpu_addr = a[AW-1:0];
      tick();
      obj_cs = 1'b0;
      check("cpu_rd_rand", {16'd0, cpu_din}, {16'd0, fm[a]});
    end
    do_copy("copy2");
    for (int i = 0; i < N; i++) bm[i] = fm[i];
    tbl_rd(3, 16'hFF34, "back_after_copy");

    // scan write-back while idle
    tbl_addr = 10'd5; tbl_din = 16'hBEEF; tbl_we = 1'b1;
    tick();
    tbl_we = 1'b0;
    bm[5] = 16'hBEEF;
    tbl_rd(5, 16'hBEEF, "tbl_we_idle");

    // copy with CPU traffic, an ignored scan write and dump probes
    for (int i = 0; i < N; i++) snap[i] = fm[i];
    swap_req = 1'b1;
    tick();
    swap_req = 1'b0;
    t = 0; n = copy_busy ? 1 : 0; dones = 0;
    while (copy_busy && t < 3000) begin
      do_w = (t % 37 == 5) && (t < 1000);
      a = 0;
      if (do_w) begin
        do a = $urandom_range(0, N - 1); while (a >= t - 1 && a <= t + 1);
        wd = 16'($urandom);
        obj_cs = 1'b1; cpu_addr = a[AW-1:0]; cpu_dout = wd; dsn = 2'b00;
      end
      tbl_we = (t == 500); tbl_addr = 10'd5; tbl_din = 16'h1111;
      if (t == 200) dump_addr = {1'b1, 10'd7};
      if (t == 300) begin dump_addr = {1'b0, 10'd1023}; dump_en = 1'b1; end
      tick();
      t++;
      obj_cs = 1'b0; dsn = 2'b11; tbl_we = 1'b0;
      if (do_w) begin
        fm[a] = wd;
        if (a > t - 1) snap[a] = wd;
      end
      if (t == 202) check("dump_front_busy", {16'd0, dump_dout}, 0);
      if (t == 302) begin
        check("dump_back_busy", {16'd0, dump_dout}, {16'd0, bm[1023]});
        dump_en = 1'b0;
      end
      if (copy_busy) n++;
      if (copy_done) dones++;
    end
    check("copy3_busy_len", n, N + 1);
    check("copy3_done", dones, 1);
    for (int i = 0; i < N; i++) bm[i] = snap[i];
    tbl_rd(5, bm[5], "tbl_we_busy_ignored");
    verify_bank(1'b0, "back3");
    verify_bank(1'b1, "front3");

    // vb rising edge copies only when AUTO_VB=1
    fill_front(1'b1);
    c1 = 0; c0 = 0; prev = 0; t = 0;
    for (int s = 0; s < 1200; s++) begin
      vb = (s < 10);
      tick();
      if (copy_busy && prev == 0) c1++;
      if (copy_busy0) c0++;
      prev = copy_busy ? 1 : 0;
    end
    vb = 1'b0;
    check("vb_copies", c1, 1);
    check("vb_no_copy_autovb0", c0, 0);
    for (int i = 0; i < N; i++) bm[i] = fm[i];
    verify_bank(1'b0, "back_vb");

    // pending: three requests in one copy give one extra copy; a request
    // coinciding with copy_done launches on the next cycle
    swap_req = 1'b1;
    tick();
    swap_req = 1'b0;
    rises = copy_busy ? 1 : 0; prev = rises; dones = 0;
    done1 = -1; rise2 = -1; done2 = -1; rise3 = -1; pulse_next = 1'b0;
    for (int s = 1; s < 3400; s++) begin
      swap_req = (s == 100) || (s == 200) || (s == 300) || pulse_next;
      pulse_next = 1'b0;
      tick();
      swap_req = 1'b0;
      if (copy_busy && prev == 0) begin
        rises++;
        if (rises == 2) rise2 = s;
        if (rises == 3) rise3 = s;
      end
      if (copy_done) begin
        dones++;
        if (dones == 1) done1 = s;
        if (dones == 2) begin done2 = s; pulse_next = 1'b1; end
      end
      prev = copy_busy ? 1 : 0;
    end
    check("pend_copies", rises, 3);
    check("pend_dones", dones, 3);
    check("pend_gap", rise2 - done1, 1);
    check("coincide_gap", rise3 - done2, 1);

    // reset during a copy at word 300
    fill_front(1'b1);
    swap_req = 1'b1;
    tick();
    swap_req = 1'b0;
    repeat (300) tick();
    rst_n = 1'b0;
    #1;
    check("rst_abort_busy", {31'd0, copy_busy}, 0);
    dones = 0;
    repeat (3) begin
      tick();
      if (copy_done) dones++;
    end
    rst_n = 1'b1;
    for (int s = 0; s < 20; s++) begin
      tick();
      if (copy_done) dones++;
    end
    check("rst_abort_no_done", dones, 0);
    for (int i = 0; i <= 298; i++) bm[i] = fm[i];
    verify_bank(1'b0, "back_partial");
    verify_bank(1'b1, "front_intact");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
